ring_counter_param: RTL and testbench

- Parametrised ring/Johnson counter with runtime-selectable mode and direction.
- Supports a one-shot step budget, parallel load, wrap and done pulses, and illegal-pattern detection with self-recovery.
- Used as a sequencer or phase generator in counter/timer subsystems.
- Outputs are tri-stated when Enable_In is low, so several counters can share a readback bus.

---
 rtl/counter_pkg.sv | 18 +
 rtl/ring_pattern_checker.sv | 20 ++
 rtl/ring_counter_param.sv | 107 ++++++++++
 tb/tb_ring_counter_param.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared mode/direction encodings, seeds and control states for the ring counter.
package counter_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;
    localparam logic DIR_LEFT     = 1'b0;
    localparam logic DIR_RIGHT    = 1'b1;

    // Seeds are width-independent integers, sized at the point of use.
    localparam int RING_SEED    = 1;
    localparam int JOHNSON_SEED = 0;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

endpackage

// File: rtl/ring_pattern_checker.sv
// ring_pattern_checker: flags whether a pattern is reachable in the given counter mode.
module ring_pattern_checker
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] pattern_i,
    input  logic             mode_i,
    output logic             legal_o
);

    logic [WIDTH-2:0] edges;

    // A Johnson pattern is a single run of ones and a single run of zeros: at most one bit boundary.
    always_comb begin
        edges   = pattern_i[WIDTH-2:0] ^ pattern_i[WIDTH-1:1];
        legal_o = (mode_i == MODE_JOHNSON) ? ($countones(edges) <= 1) : ($countones(pattern_i) == 1);
    end

endmodule

// File: rtl/ring_counter_param.sv
// ring_counter_param: falling-edge ring/Johnson counter with step budget, load,
// wrap/done pulses, illegal-pattern recovery and tri-stated readback.
module ring_counter_param
    import counter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 8
) (
    input  logic              Clk_In,
    input  logic              Reset_In,
    input  logic              Enable_In,
    input  logic              Start_Counter_Command_In,
    input  logic              Stop_Counter_Command_In,
    input  logic              Mode_In,
    input  logic              Dir_In,
    input  logic [STEP_W-1:0] Steps_In,
    input  logic              Load_In,
    input  logic [WIDTH-1:0]  Load_Value_In,
    output logic              Counter_Running_Flag_Out,
    output logic [WIDTH-1:0]  Counter_Count_Out,
    output logic              Wrap_Pulse_Out,
    output logic              Done_Pulse_Out,
    output logic              Error_Flag_Out
);

    state_e            state_q;
    logic [WIDTH-1:0]  count_q;
    logic [WIDTH-1:0]  shift_d;
    logic [WIDTH-1:0]  seed_d;
    logic [STEP_W-1:0] remaining_q;
    logic              mode_q;
    logic              dir_q;
    logic              wrap_q;
    logic              done_q;
    logic              error_q;
    logic              cur_legal;
    logic              load_legal;

    ring_pattern_checker #(.WIDTH(WIDTH)) u_cur_chk (
        .pattern_i (count_q),
        .mode_i    (mode_q),
        .legal_o   (cur_legal)
    );

    ring_pattern_checker #(.WIDTH(WIDTH)) u_load_chk (
        .pattern_i (Load_Value_In),
        .mode_i    (mode_q),
        .legal_o   (load_legal)
    );

    // Johnson differs from ring only by inverting the bit that wraps around.
    always_comb begin
        seed_d  = (mode_q == MODE_JOHNSON) ? WIDTH'(JOHNSON_SEED) : WIDTH'(RING_SEED);
        shift_d = (dir_q == DIR_RIGHT)
                ? {count_q[0] ^ (mode_q == MODE_JOHNSON), count_q[WIDTH-1:1]}
                : {count_q[WIDTH-2:0], count_q[WIDTH-1] ^ (mode_q == MODE_JOHNSON)};
    end

    always_ff @(negedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q     <= ST_IDLE;
            count_q     <= WIDTH'(RING_SEED);
            remaining_q <= '0;
            mode_q      <= MODE_RING;
            dir_q       <= DIR_LEFT;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            done_q <= 1'b0;
            if (Load_In) begin
                count_q <= load_legal ? Load_Value_In : seed_d;
                error_q <= !load_legal;
            end else if (Start_Counter_Command_In) begin
                state_q     <= ST_RUN;
                mode_q      <= Mode_In;
                dir_q       <= Dir_In;
                remaining_q <= Steps_In;
            end else if (Stop_Counter_Command_In) begin
                state_q <= ST_IDLE;
            end else if (state_q == ST_RUN) begin
                if (!cur_legal) begin
                    count_q <= seed_d;
                    error_q <= 1'b1;
                end else begin
                    count_q <= shift_d;
                    wrap_q  <= (shift_d == seed_d);
                    if (remaining_q != '0) begin
                        remaining_q <= remaining_q - 1'b1;
                        if (remaining_q == STEP_W'(1)) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign Counter_Running_Flag_Out = Enable_In ? (state_q == ST_RUN) : 1'bz;
    assign Counter_Count_Out        = Enable_In ? count_q : {WIDTH{1'bz}};
    assign Wrap_Pulse_Out           = Enable_In ? wrap_q : 1'bz;
    assign Done_Pulse_Out           = Enable_In ? done_q : 1'bz;
    assign Error_Flag_Out           = Enable_In ? error_q : 1'bz;

endmodule

// File: tb/tb_ring_counter_param.sv
// tb_ring_counter_param: directed vectors for a 4-bit ring/Johnson counter.
module tb_ring_counter_param;

    logic       clk = 1'b1;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic       dir = 1'b0;
    logic [7:0] steps = '0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    wire        run_w;
    wire  [3:0] count_w;
    wire        wrap_w;
    wire        done_w;
    wire        err_w;
    int         vectors = 0;
    int         miscompares = 0;

    // Pull-ups make released (Z) outputs read back as ones.
    for (genvar k = 0; k < 4; k++) begin : g_pu
        pullup (count_w[k]);
    end
    pullup (run_w);
    pullup (wrap_w);
    pullup (done_w);
    pullup (err_w);

    ring_counter_param #(.WIDTH(4), .STEP_W(8)) dut (
        .Clk_In                   (clk),
        .Reset_In                 (rst),
        .Enable_In                (en),
        .Start_Counter_Command_In (start),
        .Stop_Counter_Command_In  (stop),
        .Mode_In                  (mode),
        .Dir_In                   (dir),
        .Steps_In                 (steps),
        .Load_In                  (load),
        .Load_Value_In            (load_val),
        .Counter_Running_Flag_Out (run_w),
        .Counter_Count_Out        (count_w),
        .Wrap_Pulse_Out           (wrap_w),
        .Done_Pulse_Out           (done_w),
        .Error_Flag_Out           (err_w)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
        @(posedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic [3:0] c, input logic r,
                              input logic w, input logic d, input logic e);
        chk({tag, ".count"}, {4'b0, count_w}, {4'b0, c});
        chk({tag, ".run"}, {7'b0, run_w}, {7'b0, r});
        chk({tag, ".wrap"}, {7'b0, wrap_w}, {7'b0, w});
        chk({tag, ".done"}, {7'b0, done_w}, {7'b0, d});
        chk({tag, ".err"}, {7'b0, err_w}, {7'b0, e});
    endtask

    logic [3:0] ring_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] john_seq [9] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111,
                                 4'b0111, 4'b0011, 4'b0001, 4'b0000};

    initial begin
        cyc();
        expect_all("reset", 4'b0001, 0, 0, 0, 0);
        rst = 1'b0;
        // Ring, left, free-run
        start = 1'b1; mode = 1'b0; dir = 1'b0; steps = 8'd0;
        cyc();
        start = 1'b0;
        expect_all("ring_start", 4'b0001, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            expect_all($sformatf("ring_shift%0d", i), ring_seq[i], 1, i == 3, 0, 0);
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        expect_all("ring_stop", 4'b0001, 0, 0, 0, 0);
        // Johnson, right, free-run from 0001 (reaches seed on the first shift)
        start = 1'b1; mode = 1'b1; dir = 1'b1;
        cyc();
        start = 1'b0;
        expect_all("john_start", 4'b0001, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            cyc();
            expect_all($sformatf("john_shift%0d", i), john_seq[i], 1, i == 0 || i == 8, 0, 0);
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        expect_all("john_stop", 4'b0000, 0, 0, 0, 0);
        // Budgeted ring run of 3 shifts
        load = 1'b1; load_val = 4'b0001;
        cyc();
        load = 1'b0;
        expect_all("load_j0001", 4'b0001, 0, 0, 0, 0);
        start = 1'b1; mode = 1'b0; dir = 1'b0; steps = 8'd3;
        cyc();
        start = 1'b0;
        expect_all("bud_start", 4'b0001, 1, 0, 0, 0);
        cyc(); expect_all("bud1", 4'b0010, 1, 0, 0, 0);
        cyc(); expect_all("bud2", 4'b0100, 1, 0, 0, 0);
        cyc(); expect_all("bud3", 4'b1000, 0, 0, 1, 0);
        cyc(); expect_all("bud_hold", 4'b1000, 0, 0, 0, 0);
        // Load legality in ring mode
        load = 1'b1; load_val = 4'b0101;
        cyc();
        expect_all("load_bad", 4'b0001, 0, 0, 0, 1);
        load_val = 4'b0100;
        cyc();
        load = 1'b0;
        expect_all("load_good", 4'b0100, 0, 0, 0, 0);
        // 0100 is illegal as a Johnson pattern: recovery must not use a step
        start = 1'b1; mode = 1'b1; dir = 1'b0; steps = 8'd2;
        cyc();
        start = 1'b0;
        expect_all("rec_start", 4'b0100, 1, 0, 0, 0);
        cyc(); expect_all("rec_seed", 4'b0000, 1, 0, 0, 1);
        cyc(); expect_all("rec_sh1", 4'b0001, 1, 0, 0, 1);
        cyc(); expect_all("rec_sh2", 4'b0011, 0, 0, 1, 1);
        // Start+Stop together, mode/dir changes ignored mid-run, Stop holds
        load = 1'b1; load_val = 4'b0001;
        cyc();
        load = 1'b0;
        expect_all("load_j0001b", 4'b0001, 0, 0, 0, 0);
        start = 1'b1; stop = 1'b1; mode = 1'b0; dir = 1'b0; steps = 8'd0;
        cyc();
        start = 1'b0; stop = 1'b0; mode = 1'b1; dir = 1'b1;
        expect_all("start_stop", 4'b0001, 1, 0, 0, 0);
        cyc(); expect_all("ignore_mode", 4'b0010, 1, 0, 0, 0);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        expect_all("stop_hold", 4'b0010, 0, 0, 0, 0);
        cyc(); expect_all("stop_hold2", 4'b0010, 0, 0, 0, 0);
        // Output disable while counting continues
        start = 1'b1; mode = 1'b0; dir = 1'b0;
        cyc();
        start = 1'b0;
        expect_all("re_start", 4'b0010, 1, 0, 0, 0);
        en = 1'b0;
        #1 expect_all("dis0", 4'b1111, 1, 1, 1, 1);
        cyc();
        cyc();
        expect_all("dis2", 4'b1111, 1, 1, 1, 1);
        en = 1'b1;
        #1 expect_all("reen", 4'b1000, 1, 0, 0, 0);
        cyc(); expect_all("reen_wrap", 4'b0001, 1, 1, 0, 0);
        cyc(); expect_all("pre_rst", 4'b0010, 1, 0, 0, 0);
        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1 expect_all("async_rst", 4'b0001, 0, 0, 0, 0);
        rst = 1'b0;
        cyc();
        expect_all("post_rst", 4'b0001, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
